// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   - access-size encodings used on d_mask / ram_mask
//   - requester identifiers (owner of the latched request, last round-robin grant)
//   - arbiter FSM state encoding
//   - default RAM size and a helper returning access size in bytes
package mem_port_arbiter_pkg;

   localparam int unsigned MEM_BYTES_DEFAULT = 1024;

   localparam logic [1:0] MASK_BYTE = 2'b00;
   localparam logic [1:0] MASK_HALF = 2'b01;
   localparam logic [1:0] MASK_WORD = 2'b10;  // any mask with bit 1 set is a word

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_D  = 1'b1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } arb_state_e;

   // Number of bytes touched by an access with the given mask.
   function automatic logic [2:0] access_size(input logic [1:0] mask);
      if (mask[1]) begin
         access_size = 3'd4;
      end else if (mask[0]) begin
         access_size = 3'd2;
      end else begin
         access_size = 3'd1;
      end
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n         clock, asynchronous active-low reset
//   req_if, req_d      request lines from instruction fetch and load/store unit
//   en                 arbitration allowed this cycle; a grant issued while en=1
//                      is a handshake and updates the history
//   grant_if, grant_d  one-hot (or zero) grant, combinational from the requests
// On conflict the requester that did not win last time is granted. The history
// resets to D so the first conflict after reset goes to IF.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_if,
   input  logic req_d,
   input  logic en,
   output logic grant_if,
   output logic grant_d
);

   logic last_grant_q;

   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (en) begin
         grant_if = req_if & (~req_d | (last_grant_q == OWNER_D));
         grant_d  = req_d & ~grant_if;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= OWNER_D;
      end else if (grant_if || grant_d) begin
         last_grant_q <= grant_d ? OWNER_D : OWNER_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed data RAM between instruction fetch (word reads) and the
// load/store unit (byte/half/word, read/write).
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req_valid/if_req_ready      IF request handshake, if_addr byte address
//   if_resp_valid/if_rdata/if_resp_err   one-cycle IF response
//   d_req_valid/d_req_ready        D request handshake with d_we, d_addr, d_mask,
//                                  d_signed_ext, d_wdata
//   d_resp_valid/d_rdata/d_resp_err      one-cycle D response
//   ram_we/ram_addr/ram_mask/ram_signed_ext/ram_wdata   RAM drive
//   ram_rdata                      combinational RAM read data
// A request is latched on handshake (IDLE), replayed on the RAM port for one cycle
// (ACCESS) and answered for one cycle (RESP): one access every three cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction fetch
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_resp_valid,
   output logic [31:0]       if_rdata,
   output logic              if_resp_err,
   // load/store unit
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [1:0]        d_mask,
   input  logic              d_signed_ext,
   input  logic [31:0]       d_wdata,
   output logic              d_resp_valid,
   output logic [31:0]       d_rdata,
   output logic              d_resp_err,
   // RAM
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [1:0]        ram_mask,
   output logic              ram_signed_ext,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [1:0]        mask_q;
   logic              sext_q;
   logic [31:0]       wdata_q;
   logic              owner_q;
   logic              err_q;
   logic [31:0]       rdata_q;

   logic              in_idle;
   logic              handshake;
   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [1:0]        req_mask;
   logic              req_sext;
   logic [31:0]       req_wdata;
   logic              req_misaligned;
   logic [ADDR_W:0]   req_end;
   logic              req_err;
   logic              resp_if;
   logic              resp_d;

   assign in_idle = (state_q == StIdle);

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_if   (if_req_valid),
      .req_d    (d_req_valid),
      .en       (in_idle),
      .grant_if (if_req_ready),
      .grant_d  (d_req_ready)
   );

   assign handshake = if_req_ready | d_req_ready;

   // Select the granted request; IF is always a plain word read.
   always_comb begin
      req_addr  = if_addr;
      req_we    = 1'b0;
      req_mask  = MASK_WORD;
      req_sext  = 1'b0;
      req_wdata = '0;
      if (d_req_ready) begin
         req_addr  = d_addr;
         req_we    = d_we;
         req_mask  = d_mask;
         req_sext  = d_signed_ext;
         req_wdata = d_wdata;
      end
   end

   // End address is formed one bit wider so an access near the top of the address
   // space cannot wrap around and pass the range check.
   always_comb begin
      req_misaligned = 1'b0;
      if (req_mask[1]) begin
         req_misaligned = (req_addr[1:0] != 2'b00);
      end else if (req_mask[0]) begin
         req_misaligned = req_addr[0];
      end
      req_end = {1'b0, req_addr} + (ADDR_W+1)'(access_size(req_mask));
      req_err = req_misaligned | (req_end > (ADDR_W+1)'(MEM_BYTES));
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (handshake) state_d = StAccess;
         StAccess: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         mask_q  <= 2'b00;
         sext_q  <= 1'b0;
         wdata_q <= '0;
         owner_q <= OWNER_IF;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (in_idle && handshake) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            mask_q  <= req_mask;
            sext_q  <= req_sext;
            wdata_q <= req_wdata;
            owner_q <= d_req_ready ? OWNER_D : OWNER_IF;
            err_q   <= req_err;
         end
         if (state_q == StAccess) begin
            rdata_q <= (we_q || err_q) ? 32'h0 : ram_rdata;
         end
      end
   end

   // ram_we depends on the state register directly so it falls with rst_n.
   assign ram_we         = (state_q == StAccess) & we_q & ~err_q;
   assign ram_addr       = addr_q;
   assign ram_mask       = mask_q;
   assign ram_signed_ext = sext_q;
   assign ram_wdata      = wdata_q;

   assign resp_if = (state_q == StResp) & (owner_q == OWNER_IF);
   assign resp_d  = (state_q == StResp) & (owner_q == OWNER_D);

   assign if_resp_valid = resp_if;
   assign if_rdata      = resp_if ? rdata_q : 32'h0;
   assign if_resp_err   = resp_if & err_q;
   assign d_resp_valid  = resp_d;
   assign d_rdata       = resp_d ? rdata_q : 32'h0;
   assign d_resp_err    = resp_d & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte RAM and a response
// scoreboard: expected responses are queued at each handshake and popped by a
// monitor whenever a response pulse appears.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned MemBytes = 1024;

   typedef struct {
      logic        owner;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req_valid, d_req_ready, d_we, d_signed_ext, d_resp_valid, d_resp_err;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [1:0]  d_mask;
   logic        ram_we, ram_signed_ext;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [1:0]  ram_mask;

   logic [7:0]  mem [0:MemBytes-1];
   logic        clear_mem;
   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .MEM_BYTES (MemBytes),
      .ADDR_W    (32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_req_valid   (if_req_valid),
      .if_req_ready   (if_req_ready),
      .if_addr        (if_addr),
      .if_resp_valid  (if_resp_valid),
      .if_rdata       (if_rdata),
      .if_resp_err    (if_resp_err),
      .d_req_valid    (d_req_valid),
      .d_req_ready    (d_req_ready),
      .d_we           (d_we),
      .d_addr         (d_addr),
      .d_mask         (d_mask),
      .d_signed_ext   (d_signed_ext),
      .d_wdata        (d_wdata),
      .d_resp_valid   (d_resp_valid),
      .d_rdata        (d_rdata),
      .d_resp_err     (d_resp_err),
      .ram_we         (ram_we),
      .ram_addr       (ram_addr),
      .ram_mask       (ram_mask),
      .ram_signed_ext (ram_signed_ext),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata)
   );

   // Behavioural RAM: little-endian, combinational read, out-of-range bytes read 0.
   always_comb begin
      logic [7:0] b0, b1, b2, b3;
      b0 = (ram_addr < MemBytes)       ? mem[ram_addr[9:0]]         : 8'h0;
      b1 = (ram_addr + 1 < MemBytes)   ? mem[10'(ram_addr + 32'd1)] : 8'h0;
      b2 = (ram_addr + 2 < MemBytes)   ? mem[10'(ram_addr + 32'd2)] : 8'h0;
      b3 = (ram_addr + 3 < MemBytes)   ? mem[10'(ram_addr + 32'd3)] : 8'h0;
      if (ram_mask[1]) begin
         ram_rdata = {b3, b2, b1, b0};
      end else if (ram_mask[0]) begin
         ram_rdata = {{16{ram_signed_ext & b1[7]}}, b1, b0};
      end else begin
         ram_rdata = {{24{ram_signed_ext & b0[7]}}, b0};
      end
   end

   always @(posedge clk) begin
      if (clear_mem) begin
         for (int i = 0; i < MemBytes; i++) mem[i] <= 8'h0;
      end else if (ram_we) begin
         if (ram_addr < MemBytes) mem[ram_addr[9:0]] <= ram_wdata[7:0];
         if (ram_mask != MASK_BYTE && ram_addr + 1 < MemBytes)
            mem[10'(ram_addr + 32'd1)] <= ram_wdata[15:8];
         if (ram_mask[1] && ram_addr + 3 < MemBytes) begin
            mem[10'(ram_addr + 32'd2)] <= ram_wdata[23:16];
            mem[10'(ram_addr + 32'd3)] <= ram_wdata[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor / scoreboard.
   always @(negedge clk) begin
      if (rst_n && (if_resp_valid || d_resp_valid)) begin
         check("resp_one_hot", {31'h0, if_resp_valid & d_resp_valid}, 32'h0);
         if (sb_q.size() == 0) begin
            check("resp_unexpected", 32'h1, 32'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("resp_owner", {31'h0, d_resp_valid}, {31'h0, e.owner});
            if (d_resp_valid) begin
               check("d_rdata", d_rdata, e.rdata);
               check("d_err", {31'h0, d_resp_err}, {31'h0, e.err});
            end else begin
               check("if_rdata", if_rdata, e.rdata);
               check("if_err", {31'h0, if_resp_err}, {31'h0, e.err});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      if_req_valid = 1'b0; if_addr = 32'h0;
      d_req_valid = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_mask = 2'b00;
      d_signed_ext = 1'b0; d_wdata = 32'h0;
   endtask

   task automatic check_reset_outputs();
      check("rst_if_ready", {31'h0, if_req_ready}, 32'h0);
      check("rst_d_ready", {31'h0, d_req_ready}, 32'h0);
      check("rst_if_resp", {31'h0, if_resp_valid}, 32'h0);
      check("rst_d_resp", {31'h0, d_resp_valid}, 32'h0);
      check("rst_ram_we", {31'h0, ram_we}, 32'h0);
      check("rst_ram_addr", ram_addr, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
   endtask

   // One request from IDLE: handshake must occur immediately, then ACCESS, then RESP.
   // Returns at the RESP-cycle falling edge.
   task automatic do_req(input logic own, input logic we, input logic [31:0] addr,
                         input logic [1:0] mask, input logic sext, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      @(negedge clk);
      if (own == OWNER_D) begin
         d_req_valid = 1'b1; d_we = we; d_addr = addr; d_mask = mask;
         d_signed_ext = sext; d_wdata = wdata;
      end else begin
         if_req_valid = 1'b1; if_addr = addr;
      end
      #1;
      check("req_ready", {31'h0, own ? d_req_ready : if_req_ready}, 32'h1);
      e.owner = own; e.rdata = exp_rdata; e.err = exp_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      // Scramble inputs: the DUT must work from its latched copy.
      idle_inputs();
      d_addr = 32'h0000_0100; d_wdata = 32'h5555_5555; if_addr = 32'h0000_0200;
      @(negedge clk);
      check("acc_ram_we", {31'h0, ram_we}, {31'h0, we & ~exp_err});
      check("acc_ram_addr", ram_addr, addr);
      if (we && own == OWNER_D) check("acc_ram_wdata", ram_wdata, wdata);
      check("acc_no_resp", {31'h0, if_resp_valid | d_resp_valid}, 32'h0);
      @(negedge clk);
      check("resp_valid", {31'h0, own ? d_resp_valid : if_resp_valid}, 32'h1);
      check("resp_ram_we", {31'h0, ram_we}, 32'h0);
      check("resp_no_ready", {31'h0, if_req_ready | d_req_ready}, 32'h0);
      idle_inputs();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      clear_mem = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clear_mem = 1'b0;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ram_we", {31'h0, ram_we}, 32'h0);
      check("idle_no_resp", {31'h0, if_resp_valid | d_resp_valid}, 32'h0);

      // Word store/load.
      do_req(OWNER_D, 1'b1, 32'h10, MASK_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
      do_req(OWNER_D, 1'b0, 32'h10, MASK_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
      // Byte store, signed and unsigned byte loads.
      do_req(OWNER_D, 1'b1, 32'h21, MASK_BYTE, 1'b0, 32'h1234_5680, 32'h0, 1'b0);
      do_req(OWNER_D, 1'b0, 32'h21, MASK_BYTE, 1'b1, 32'h0, 32'hFFFF_FF80, 1'b0);
      do_req(OWNER_D, 1'b0, 32'h21, MASK_BYTE, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
      // Alignment and range errors.
      do_req(OWNER_D, 1'b0, 32'h03, MASK_HALF, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req(OWNER_IF, 1'b0, 32'h02, MASK_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req(OWNER_D, 1'b0, 32'h3FE, MASK_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req(OWNER_D, 1'b1, 32'h3FE, MASK_WORD, 1'b0, 32'h1234_5678, 32'h0, 1'b1);
      do_req(OWNER_D, 1'b0, 32'h3FF, MASK_BYTE, 1'b0, 32'h0, 32'h0, 1'b0);
      do_req(OWNER_D, 1'b1, 32'h11, MASK_HALF, 1'b0, 32'h0000_AAAA, 32'h0, 1'b1);
      do_req(OWNER_D, 1'b0, 32'h10, MASK_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
      do_req(OWNER_D, 1'b0, 32'h3FC, MASK_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
      do_req(OWNER_D, 1'b0, 32'hFFFF_FFFC, MASK_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req(OWNER_IF, 1'b0, 32'h10, MASK_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);

      // Conflicts from reset: grants alternate IF, D, IF, D.
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         logic exp_if;
         exp_if = (i % 2 == 0);
         @(negedge clk);
         if_req_valid = 1'b1; if_addr = 32'h10;
         d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_mask = MASK_WORD;
         #1;
         check("rr_if_ready", {31'h0, if_req_ready}, {31'h0, exp_if});
         check("rr_d_ready", {31'h0, d_req_ready}, {31'h0, ~exp_if});
         e.owner = exp_if ? OWNER_IF : OWNER_D;
         e.rdata = exp_if ? 32'hDEAD_BEEF : 32'h0000_8000;
         e.err   = 1'b0;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         if (i == 3) idle_inputs();
         @(negedge clk);
         check("rr_acc_no_ready", {31'h0, if_req_ready | d_req_ready}, 32'h0);
         @(negedge clk);
         check("rr_resp_no_ready", {31'h0, if_req_ready | d_req_ready}, 32'h0);
      end

      // Reset during the ACCESS cycle of a store: no write, no response.
      @(negedge clk);
      d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_mask = MASK_WORD;
      d_wdata = 32'hCAFE_F00D;
      #1;
      check("mid_ready", {31'h0, d_req_ready}, 32'h1);
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      check("mid_ram_we_acc", {31'h0, ram_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_ram_we_drop", {31'h0, ram_we}, 32'h0);
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      do_req(OWNER_D, 1'b0, 32'h40, MASK_WORD, 1'b0, 32'h0, 32'h0, 1'b0);

      repeat (2) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
